// File: rtl/spi_phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_phy_pkg
//  Description : Shared state encoding, word-size constants and helper for
//                the SPI mode-0 master PHY.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_phy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  localparam int SPI_BITS_NARROW = 8;
  localparam int SPI_BITS_WIDE   = 32;

  // Number of bits shifted for a transfer of the requested width
  function automatic logic [5:0] spi_bits(input logic wide);
    return wide ? 6'(SPI_BITS_WIDE) : 6'(SPI_BITS_NARROW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sck_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sck_gen
//  Description : SCK divider. While enabled, holds SCK low for CLK_DIV cycles
//                then high for CLK_DIV cycles, and flags the cycle on whose
//                closing edge SCK rises or falls. Disabled = SCK low, counter 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                CW     = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]     C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          sck_q;
  logic          w_toggle;

  assign w_toggle = en_i && (cnt_q == C_LAST);
  assign rise_o   = w_toggle && !sck_q;
  assign fall_o   = w_toggle &&  sck_q;
  assign sck_o    = sck_q;

  // Half-period counter; restarts from zero every time the shifter re-enables it
  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (w_toggle) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_phy.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_phy
//  Description : SPI mode-0 master PHY. Accepts an 8- or 32-bit word on the
//                spi_begin/spi_busy handshake, shifts it MSB-first on MOSI,
//                captures MISO on SCK rising and manages CS from spi_cs.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_phy
  import spi_phy_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_begin,
  input  logic        spi_wide,
  input  logic        spi_cs,
  input  logic [31:0] spi_mosi,
  output logic [31:0] spi_miso,
  output logic        spi_busy,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  spi_state_e  state_q;
  logic [31:0] tx_q;          // transmit word, MSB-aligned to bit 31
  logic [31:0] rx_q;          // receive shift register, fills from bit 0
  logic [31:0] rx_word_q;
  logic [5:0]  nbits_q;
  logic [5:0]  bitcnt_q;
  logic        release_q;
  logic        armed_q;
  logic        busy_q;
  logic        mosi_q;
  logic        cs_n_q;

  logic        w_sck;
  logic        w_rise;
  logic        w_fall;
  logic        w_accept;
  logic [5:0]  w_bitcnt_nxt;

  assign w_accept     = (state_q == IDLE) && spi_begin && armed_q;
  assign w_bitcnt_nxt = bitcnt_q + 6'd1;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == SHIFT),
    .sck_o  (w_sck),
    .rise_o (w_rise),
    .fall_o (w_fall)
  );

  // Transfer sequencer: IDLE -> LEAD -> SHIFT (N bits) -> TRAIL -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_word_q <= '0;
      nbits_q   <= '0;
      bitcnt_q  <= '0;
      release_q <= 1'b1;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      // A low begin level re-arms; only a fresh high level can start a word
      if (!spi_begin) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          cs_n_q <= spi_cs;
          if (w_accept) begin
            armed_q   <= 1'b0;
            tx_q      <= spi_wide ? spi_mosi : {spi_mosi[7:0], 24'h0};
            mosi_q    <= spi_wide ? spi_mosi[31] : spi_mosi[7];
            nbits_q   <= spi_bits(spi_wide);
            release_q <= spi_cs;
            rx_q      <= '0;
            bitcnt_q  <= '0;
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= LEAD;
          end
        end
        LEAD: begin
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (w_rise) begin
            rx_q <= {rx_q[30:0], miso};
          end
          if (w_fall) begin
            bitcnt_q <= w_bitcnt_nxt;
            if (w_bitcnt_nxt == nbits_q) begin
              state_q <= TRAIL;
            end else begin
              tx_q   <= {tx_q[30:0], 1'b0};
              mosi_q <= tx_q[30];
            end
          end
        end
        TRAIL: begin
          rx_word_q <= rx_q;
          cs_n_q    <= release_q;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign spi_miso = rx_word_q;
  assign spi_busy = busy_q;
  assign sck      = w_sck;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_phy.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_phy
//  Description : Self-checking bench for spi_master_phy. A transaction-level
//                timeline model predicts busy/sck/mosi/cs_n/spi_miso for every
//                cycle; directed and randomized transfers drive the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_phy;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_begin;
  logic        spi_wide;
  logic        spi_cs;
  logic [31:0] spi_mosi;
  logic [31:0] spi_miso;
  logic        spi_busy;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic        cs_n;

  logic        b_begin;
  logic [31:0] b_miso_word;
  logic        b_busy;
  logic        b_sck;
  logic        b_mosi;
  logic        b_cs_n;

  always #5 clk = ~clk;

  spi_master_phy #(.CLK_DIV(D)) u_dut (
    .clk(clk), .rst(rst), .spi_begin(spi_begin), .spi_wide(spi_wide),
    .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_busy(spi_busy), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_master_phy #(.CLK_DIV(1)) u_dut_div1 (
    .clk(clk), .rst(rst), .spi_begin(b_begin), .spi_wide(1'b0),
    .spi_cs(1'b0), .spi_mosi(32'h0000_0012), .spi_miso(b_miso_word),
    .spi_busy(b_busy), .sck(b_sck), .mosi(b_mosi), .miso(1'b1), .cs_n(b_cs_n)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int          cyc = 0;
  bit          m_active = 1'b0;
  bit          m_armed  = 1'b0;
  bit          m_loop   = 1'b1;
  bit          loop_mode;
  int          m_A = 0;
  int          m_N = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_pat  = '0;
  bit          m_release = 1'b1;
  logic        m_cs_n = 1'b1;
  logic [31:0] m_spi_miso = '0;
  logic        miso_r = 1'b0;

  // Decide accepts/completions from the inputs of the cycle just ending
  always @(posedge clk) begin : p_model
    int c;
    c = cyc;
    if (rst) begin
      m_active   = 1'b0;
      m_armed    = 1'b0;
      m_cs_n     = 1'b1;
      m_spi_miso = '0;
    end else if (!m_active && spi_begin && m_armed) begin
      m_A       = c;
      m_N       = spi_wide ? 32 : 8;
      m_data    = spi_wide ? spi_mosi : {24'h0, spi_mosi[7:0]};
      m_pat     = $urandom & (spi_wide ? 32'hFFFF_FFFF : 32'h0000_00FF);
      m_release = spi_cs;
      m_loop    = loop_mode;
      m_armed   = 1'b0;
      m_active  = 1'b1;
      m_cs_n    = 1'b0;
    end else begin
      if (!spi_begin) m_armed = 1'b1;
      if (m_active) begin
        if (c == m_A + 2 + 2 * D * m_N) begin
          m_active   = 1'b0;
          m_spi_miso = m_loop ? m_data : m_pat;
          m_cs_n     = m_release;
        end else begin
          m_cs_n = 1'b0;
        end
      end else begin
        m_cs_n = spi_cs;
      end
    end
    cyc = c + 1;
  end

  // Slave side: in non-loopback mode present pattern bit b for the whole bit window
  always @(posedge clk) begin : p_slave
    int k;
    #1;
    k = cyc - m_A - 1;
    if (m_active && k >= 1 && k <= 2 * D * m_N)
      miso_r = m_pat[m_N - 1 - (k - 1) / (2 * D)];
    else
      miso_r = 1'($urandom);
  end

  assign miso = m_loop ? mosi : miso_r;

  // ---------------- monitor + per-cycle compare ----------------
  int          busy_run = 0;
  int          rises = 0;
  int          n_accepts = 0;
  logic [31:0] cap = '0;
  logic        prev_sck = 1'b0;
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin : p_compare
    int   k;
    int   bi;
    logic e_sck;
    if (spi_busy === 1'b1 && prev_busy !== 1'b1) begin
      n_accepts++;
      busy_run = 0;
      rises    = 0;
      cap      = '0;
    end
    if (spi_busy === 1'b1) busy_run++;
    if (sck === 1'b1 && prev_sck !== 1'b1) begin
      rises++;
      cap = {cap[30:0], mosi};
    end
    prev_sck  = sck;
    prev_busy = spi_busy;
    if (chk_en) begin
      k     = cyc - m_A - 1;
      e_sck = m_active && k >= 1 && k <= 2 * D * m_N && (((k - 1) % (2 * D)) >= D);
      chk("busy", {31'h0, spi_busy}, {31'h0, m_active});
      chk("sck", {31'h0, sck}, {31'h0, e_sck});
      chk("cs_n", {31'h0, cs_n}, {31'h0, m_cs_n});
      chk("spi_miso", spi_miso, m_spi_miso);
      if (m_active && k >= 0 && k <= 2 * D * m_N) begin
        bi = (k == 0) ? m_N - 1 : m_N - 1 - (k - 1) / (2 * D);
        chk("mosi", {31'h0, mosi}, {31'h0, m_data[bi]});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic level, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (spi_busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (spi_busy !== level) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: busy=%b, expected %b", name, spi_busy, level);
    end
  endtask

  task automatic xfer(input logic [31:0] d, input logic w, input logic cs,
                      input bit lp, input bit scramble);
    tick();
    spi_mosi  = d;
    spi_wide  = w;
    spi_cs    = cs;
    loop_mode = lp;
    spi_begin = 1'b1;
    wait_busy(1'b1, 10, "xfer_start");
    tick();
    spi_begin = 1'b0;
    if (scramble) begin
      spi_mosi = $urandom;
      spi_wide = 1'($urandom);
      spi_cs   = 1'($urandom);
    end
    wait_busy(1'b0, 300, "xfer_done");
  endtask

  initial begin : p_watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin : p_main
    int a0;
    int r;
    int n;
    int len;
    logic ps;
    rst = 1'b1; spi_begin = 1'b0; spi_wide = 1'b0; spi_cs = 1'b1;
    spi_mosi = '0; loop_mode = 1'b1; b_begin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", {31'h0, spi_busy}, 32'h0);
    chk("rst_sck", {31'h0, sck}, 32'h0);
    chk("rst_cs_n", {31'h0, cs_n}, 32'h1);
    chk("rst_spi_miso", spi_miso, 32'h0);

    // 8-bit 0xA5 loopback, CS held selected
    tick();
    spi_cs = 1'b0;
    repeat (2) tick();
    xfer(32'h0000_00A5, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_busy_len", busy_run, 34);
    chk("t1_rises", rises, 8);
    chk("t1_mosi_bits", cap, 32'h0000_00A5);
    chk("t1_spi_miso", spi_miso, 32'h0000_00A5);
    chk("t1_cs_n", {31'h0, cs_n}, 32'h0);

    // 32-bit 0xDEADBEEF loopback
    xfer(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2_busy_len", busy_run, 130);
    chk("t2_rises", rises, 32);
    chk("t2_mosi_bits", cap, 32'hDEAD_BEEF);
    chk("t2_spi_miso", spi_miso, 32'hDEAD_BEEF);

    // Begin held past completion: one transfer only; then 1-cycle drop re-triggers
    tick();
    a0 = n_accepts;
    spi_mosi = 32'h0000_005A; spi_wide = 1'b0; loop_mode = 1'b1; spi_begin = 1'b1;
    wait_busy(1'b1, 10, "t3_start");
    wait_busy(1'b0, 100, "t3_done");
    repeat (40) tick();
    chk("t3_single_accept", n_accepts - a0, 1);
    spi_begin = 1'b0;
    tick();
    spi_begin = 1'b1;
    tick();
    chk("t3_restart", {31'h0, spi_busy}, 32'h1);
    spi_begin = 1'b0;
    wait_busy(1'b0, 100, "t3_done2");

    // CS released after a word accepted with spi_cs=1
    tick();
    spi_cs = 1'b0;
    repeat (3) tick();
    chk("t4_cs_idle", {31'h0, cs_n}, 32'h0);
    xfer(32'h0000_0081, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_cs_release", {31'h0, cs_n}, 32'h1);
    chk("t4_spi_miso", spi_miso, 32'h0000_0081);

    // Reset mid-transfer, then a normal transfer
    tick();
    spi_cs = 1'b0; spi_mosi = 32'h0000_003C; spi_wide = 1'b0; loop_mode = 1'b1;
    spi_begin = 1'b1;
    wait_busy(1'b1, 10, "t5_start");
    r = 0; n = 0; ps = sck;
    while (r < 3 && n < 200) begin
      @(negedge clk);
      if (sck && !ps) r++;
      ps = sck;
      n++;
    end
    chk("t5_reach_bit3", r, 3);
    tick();
    rst = 1'b1;
    spi_begin = 1'b0;
    tick();
    rst = 1'b0;
    chk("t5_sck", {31'h0, sck}, 32'h0);
    chk("t5_cs_n", {31'h0, cs_n}, 32'h1);
    chk("t5_busy", {31'h0, spi_busy}, 32'h0);
    chk("t5_spi_miso", spi_miso, 32'h0);
    xfer(32'h0000_0055, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_next_miso", spi_miso, 32'h0000_0055);
    chk("t5_next_len", busy_run, 34);

    // CLK_DIV=1, miso tied high
    tick();
    b_begin = 1'b1;
    n = 0; len = 0;
    @(negedge clk);
    while (!b_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    while (b_busy && len < 100) begin
      len++;
      @(negedge clk);
    end
    chk("t6_busy_len", len, 18);
    chk("t6_spi_miso", b_miso_word, 32'h0000_00FF);
    tick();
    b_begin = 1'b0;

    // Randomized transfers (mixed width, CS, loopback/pattern MISO, input scramble)
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      xfer($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Back-to-back: re-armed while busy, accepted on the first IDLE cycle
    tick();
    spi_mosi = $urandom; spi_wide = 1'b0; loop_mode = 1'b0; spi_begin = 1'b1;
    wait_busy(1'b1, 10, "b2b_start");
    tick();
    spi_begin = 1'b0;
    tick();
    spi_begin = 1'b1;
    spi_mosi  = $urandom;
    wait_busy(1'b0, 100, "b2b_done1");
    @(negedge clk);
    chk("b2b_restart", {31'h0, spi_busy}, 32'h1);
    tick();
    spi_begin = 1'b0;
    wait_busy(1'b0, 100, "b2b_done2");

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
